pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage processor (F, D, E, M, W).
- Drives `enable` and synchronous `reset` (clear) of the four reg32 pipeline registers (FD, DE, EM, MW) and the PC-load enable.
- Resolves stalls, bubbles and flushes from memory wait, load-use hazards, multicycle multiply, taken branches and exceptions.
- Tracks per-stage valid bits and a stall performance counter.

Parameters:
- MUL_LAT, 4, total cycles a multiply occupies E (≥1; 1 means no stall).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ic_busy  in  1  instruction memory not ready; F has no instruction.
- dc_busy  in  1  data memory not ready; M must hold.
- d_load_use  in  1  instruction in D depends on a load in E.
- e_is_mul  in  1  instruction in E is a multiply; ignored unless stage_valid[1].
- e_branch_taken  in  1  branch in E resolved taken; ignored unless stage_valid[1].
- m_exception  in  1  exception raised in M; ignored unless stage_valid[2].
- pc_en  out  1  PC register enable.
- pc_sel_exc  out  1  PC mux selects exception vector.
- en_fd, en_de, en_em, en_mw  out  1 each  pipeline register enables.
- clr_fd, clr_de, clr_em, clr_mw  out  1 each  pipeline register synchronous clears (to reg32 reset).
- stage_valid  out  4  valid bits of D, E, M, W = [0..3].
- stall_cause  out  3  active cause code (pipe_pkg enum).
- stall_cnt  out  CNT_W  cycles with pc_en=0 since reset, saturating.

Behaviour:
- Outputs are combinational from state and inputs. Only stage_valid, mul_cnt and stall_cnt are registered.
- Reset asserted:
  - All en_* = 1, all clr_* = 1, pc_en = 0, pc_sel_exc = 0, stall_cause = NONE.
  - Next edge: stage_valid = 0, mul_cnt = 0, stall_cnt = 0.
  - Reset mid-stall or mid-multiply abandons everything.
- mul_stall = e_is_mul & stage_valid[1] & (mul_cnt != MUL_LAT-1).
- Priority, highest first; exactly one case applies per cycle:
  1. EXC (m_exception valid): pc_en = 1, pc_sel_exc = 1, all en = 1, clr_fd/de/em/mw = 1. The instruction already in W retires. Overrides dc_busy.
  2. DC (dc_busy): pc_en = 0, en_fd/de/em = 0, en_mw = 1 with clr_mw = 1 (bubble into W).
  3. MUL (mul_stall): pc_en = 0, en_fd/de = 0, en_em = 1 with clr_em = 1 (bubble into M), en_mw = 1. mul_cnt += 1.
  4. BR (e_branch_taken valid): pc_en = 1 (target), all en = 1, clr_fd = clr_de = 1 (squash F and D). Wins over load-use and ic_busy.
  5. LU (d_load_use): pc_en = 0, en_fd = 0, en_de = 1 with clr_de = 1, en_em = en_mw = 1.
  6. IC (ic_busy): pc_en = 0, en_fd = 1 with clr_fd = 1, rest advance.
  7. NONE: pc_en = 1, all en = 1, no clears.
- mul_cnt:
  - Clears to 0 whenever en_em = 1 and clr_em = 0, i.e. E advances. A mul reaching E therefore stalls exactly MUL_LAT-1 cycles.
  - Holds under DC; clears under EXC.
  - With MUL_LAT = 1 it is never incremented.
- stage_valid update per register X with upstream u:
  - clr_X → 0; else en_X → u; else hold.
  - u for D is 1; for E, M, W it is the previous stage's valid.
- stall_cnt: +1 on every non-reset cycle with pc_en = 0; holds at 2^CNT_W-1.
- Simultaneous events resolve strictly by the priority list. Lower-priority requests stay asserted by their sources and are served later.

Decomposition:
- pipe_pkg holds:
  - stall_cause enum: NONE=0, IC=1, LU=2, BR=3, MUL=4, DC=5, EXC=6.
  - Stage index constants: D=0, E=1, M=2, W=3.
- One sub-module: pipe_sat_counter (parameter WIDTH; ports clk, reset, inc, count), used for stall_cnt.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 → cycle after reset: all clr = 1, stall_cnt = 0. After 4 free cycles: stage_valid = 4'b1111, cause NONE.
- Valid mul reaches E with MUL_LAT = 4 and e_is_mul held → exactly 3 cycles of pc_en = 0 and cause MUL, with clr_em = 1 in each. 4th cycle advances. stall_cnt = 3.
- dc_busy for 2 cycles while d_load_use = 1 → cause DC both cycles, en_em = 0, stage_valid[3] = 0 after. Next cycle cause LU.
- e_branch_taken with ic_busy = 1 at stage_valid = 4'b1111 → pc_en = 1, clr_fd = clr_de = 1. Next stage_valid = 4'b1100 (D, E invalid).
- m_exception with dc_busy = 1 → cause EXC, pc_sel_exc = 1, all four clr = 1. Next stage_valid = 0.
- CNT_W = 4, ic_busy held 20 cycles → stall_cnt saturates at 15. Reset mid-hold → 0 on next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencer.
package pipe_pkg;

  localparam int unsigned NUM_STAGES = 4;
  localparam int unsigned CAUSE_W    = 3;

  // Indices into stage_valid and into the per-register enable/clear vectors.
  localparam int unsigned STAGE_D = 0;
  localparam int unsigned STAGE_E = 1;
  localparam int unsigned STAGE_M = 2;
  localparam int unsigned STAGE_W = 3;

  // Reason the pipeline is not running freely this cycle.
  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_IC   = 3'd1,
    CAUSE_LU   = 3'd2,
    CAUSE_BR   = 3'd3,
    CAUSE_MUL  = 3'd4,
    CAUSE_DC   = 3'd5,
    CAUSE_EXC  = 3'd6
  } stall_cause_e;

  // Control bundle for PC and the FD/DE/EM/MW registers (bit = stage index).
  typedef struct packed {
    logic                  pc_en;
    logic                  pc_sel_exc;
    logic [NUM_STAGES-1:0] en;
    logic [NUM_STAGES-1:0] clr;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module pipe_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: enables/clears for FD, DE, EM, MW and PC, with
// prioritised handling of exceptions, memory waits, multiply, branches,
// load-use hazards and fetch misses.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_busy,
  input  logic             dc_busy,
  input  logic             d_load_use,
  input  logic             e_is_mul,
  input  logic             e_branch_taken,
  input  logic             m_exception,
  output logic             pc_en,
  output logic             pc_sel_exc,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             clr_fd,
  output logic             clr_de,
  output logic             clr_em,
  output logic             clr_mw,
  output logic [3:0]       stage_valid,
  output logic [2:0]       stall_cause,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MUL_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  pipe_ctl_t                 ctl;
  stall_cause_e              cause;
  logic [MUL_W-1:0]          mul_cnt;
  logic                      mul_inc;
  logic                      mul_hold;
  logic                      mul_stall;
  logic                      exc_req;
  logic                      br_req;
  logic [NUM_STAGES-1:0]     upstream;

  assign exc_req   = m_exception & stage_valid[STAGE_M];
  assign br_req    = e_branch_taken & stage_valid[STAGE_E];
  assign mul_stall = e_is_mul & stage_valid[STAGE_E] &
                     (mul_cnt != MUL_W'(MUL_LAT - 1));

  // Pick exactly one action per cycle by fixed priority.
  always_comb begin
    ctl.pc_en      = 1'b1;
    ctl.pc_sel_exc = 1'b0;
    ctl.en         = '1;
    ctl.clr        = '0;
    cause          = CAUSE_NONE;
    mul_inc        = 1'b0;
    mul_hold       = 1'b0;
    if (reset) begin
      ctl.pc_en = 1'b0;
      ctl.clr   = '1;
    end else if (exc_req) begin
      ctl.pc_sel_exc = 1'b1;
      ctl.clr        = '1;
      cause          = CAUSE_EXC;
    end else if (dc_busy) begin
      ctl.pc_en          = 1'b0;
      ctl.en             = '0;
      ctl.en[STAGE_W]    = 1'b1;
      ctl.clr[STAGE_W]   = 1'b1;
      mul_hold           = 1'b1;
      cause              = CAUSE_DC;
    end else if (mul_stall) begin
      ctl.pc_en          = 1'b0;
      ctl.en[STAGE_D]    = 1'b0;
      ctl.en[STAGE_E]    = 1'b0;
      ctl.clr[STAGE_M]   = 1'b1;
      mul_inc            = 1'b1;
      cause              = CAUSE_MUL;
    end else if (br_req) begin
      ctl.clr[STAGE_D]   = 1'b1;
      ctl.clr[STAGE_E]   = 1'b1;
      cause              = CAUSE_BR;
    end else if (d_load_use) begin
      ctl.pc_en          = 1'b0;
      ctl.en[STAGE_D]    = 1'b0;
      ctl.clr[STAGE_E]   = 1'b1;
      cause              = CAUSE_LU;
    end else if (ic_busy) begin
      ctl.pc_en          = 1'b0;
      ctl.clr[STAGE_D]   = 1'b1;
      cause              = CAUSE_IC;
    end
  end

  assign pc_en       = ctl.pc_en;
  assign pc_sel_exc  = ctl.pc_sel_exc;
  assign en_fd       = ctl.en[STAGE_D];
  assign en_de       = ctl.en[STAGE_E];
  assign en_em       = ctl.en[STAGE_M];
  assign en_mw       = ctl.en[STAGE_W];
  assign clr_fd      = ctl.clr[STAGE_D];
  assign clr_de      = ctl.clr[STAGE_E];
  assign clr_em      = ctl.clr[STAGE_M];
  assign clr_mw      = ctl.clr[STAGE_W];
  assign stall_cause = cause;

  // Multiply occupancy: counts while stalling, frozen by a memory wait,
  // zero whenever E advances or is flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_cnt <= '0;
    end else if (mul_inc) begin
      mul_cnt <= mul_cnt + MUL_W'(1);
    end else if (!mul_hold) begin
      mul_cnt <= '0;
    end
  end

  // D always receives a fetched slot; later stages inherit their predecessor.
  assign upstream = {stage_valid[2:0], 1'b1};

  // Valid bits follow the same clear/enable as their pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (ctl.clr[i]) begin
          stage_valid[i] <= 1'b0;
        end else if (ctl.en[i]) begin
          stage_valid[i] <= upstream[i];
        end
      end
    end
  end

  pipe_sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~ctl.pc_en),
    .count (stall_cnt)
  );

endmodule
